// File: rtl/mult_div_defs.sv
// Shared definitions for the iterative multiply/divide unit:
// operation and state encodings, the iteration count and small op helpers.
package mult_div_defs;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_t;

    localparam int ITERATIONS = 32;
    localparam logic [4:0] LAST_COUNT = 5'(ITERATIONS - 1);

    function automatic logic is_div_op(input op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/negate_cond_64.sv
// Conditional 64-bit two's-complement negation; 32-bit users feed the low half
// and take the low half of the result.
module negate_cond_64 (
    input  logic [63:0] value,
    input  logic        negate,
    output logic [63:0] result
);

    assign result = negate ? (~value + 64'd1) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit writing the HI/LO pair; runs on
// magnitudes for 32 cycles, then applies the result signs in a FIX cycle.
module mult_div_unit
    import mult_div_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  in_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        in_mthi,
    input  logic        in_mtlo,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    state_t      state, next_state;
    op_t         op_q;
    op_t         new_op;
    logic [4:0]  count;
    logic [63:0] acc;
    logic [31:0] operand;
    logic        sign_diff;
    logic        a_neg;
    logic        b_zero;
    logic [31:0] hi_q, lo_q;
    logic        done_q;

    logic [63:0] abs_a, abs_b;
    logic [63:0] fix_main, fix_rem;
    logic [63:0] fix_main_in;
    logic [32:0] mult_sum;
    logic [33:0] div_diff;
    logic [32:0] partial;
    logic [63:0] step_acc;
    logic        unused_bits;

    assign new_op = op_t'(in_op);

    negate_cond_64 u_abs_a (
        .value  ({32'd0, A}),
        .negate (is_signed_op(new_op) && A[31]),
        .result (abs_a)
    );

    negate_cond_64 u_abs_b (
        .value  ({32'd0, B}),
        .negate (is_signed_op(new_op) && B[31]),
        .result (abs_b)
    );

    // Multiply corrects the whole product; divide corrects the quotient here
    // and the remainder (which follows the dividend's sign) separately.
    assign fix_main_in = is_div_op(op_q) ? {32'd0, acc[31:0]} : acc;

    negate_cond_64 u_fix_main (
        .value  (fix_main_in),
        .negate (sign_diff),
        .result (fix_main)
    );

    negate_cond_64 u_fix_rem (
        .value  ({32'd0, acc[63:32]}),
        .negate (a_neg),
        .result (fix_rem)
    );

    assign unused_bits = ^{abs_a[63:32], abs_b[63:32], fix_rem[63:32]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start) next_state = ST_CALC;
            ST_CALC: if (count == LAST_COUNT) next_state = ST_FIX;
            ST_FIX:  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // One radix-2 step: shift-add for multiply, restoring shift-subtract for
    // divide. The partial remainder needs 33 bits before the subtract.
    always_comb begin
        mult_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
        partial  = acc[63:31];
        div_diff = {1'b0, partial} - {2'b00, operand};
        step_acc = {mult_sum, acc[31:1]};
        if (is_div_op(op_q)) begin
            if (!div_diff[33]) begin
                step_acc = {div_diff[31:0], acc[30:0], 1'b1};
            end else begin
                step_acc = {partial[31:0], acc[30:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= OP_MULT;
            count     <= 5'd0;
            acc       <= 64'd0;
            operand   <= 32'd0;
            sign_diff <= 1'b0;
            a_neg     <= 1'b0;
            b_zero    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q      <= new_op;
                        count     <= 5'd0;
                        sign_diff <= is_signed_op(new_op) && (A[31] ^ B[31]);
                        a_neg     <= is_signed_op(new_op) && A[31];
                        b_zero    <= (B == 32'd0);
                        if (is_div_op(new_op)) begin
                            acc     <= {32'd0, abs_a[31:0]};
                            operand <= abs_b[31:0];
                        end else begin
                            acc     <= {32'd0, abs_b[31:0]};
                            operand <= abs_a[31:0];
                        end
                    end else begin
                        if (in_mthi) hi_q <= A;
                        if (in_mtlo) lo_q <= A;
                    end
                end
                ST_CALC: begin
                    acc   <= step_acc;
                    count <= count + 5'd1;
                end
                ST_FIX: begin
                    done_q <= 1'b1;
                    if (is_div_op(op_q)) begin
                        hi_q <= fix_rem[31:0];
                        lo_q <= b_zero ? 32'hFFFF_FFFF : fix_main[31:0];
                    end else begin
                        hi_q <= fix_main[63:32];
                        lo_q <= fix_main[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized checks for mult_div_unit: table of hand-computed
// results issued back-to-back, plus busy-time, mt-write and reset sequences.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  in_op;
    logic [31:0] A, B;
    logic        in_mthi, in_mtlo;
    logic        busy, done;
    logic [31:0] HI, LO;

    int total = 0;
    int bad = 0;
    logic [31:0] last_hi, last_lo;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[7];

    mult_div_unit dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .in_op   (in_op),
        .A       (A),
        .B       (B),
        .in_mthi (in_mthi),
        .in_mtlo (in_mtlo),
        .busy    (busy),
        .done    (done),
        .HI      (HI),
        .LO      (LO)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Reference results computed from native 64-bit arithmetic.
    function automatic logic [63:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        case (op)
            2'b00: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p = 64'(sa * sb);
                return p;
            end
            2'b01: return {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        in_op = op;
        A     = a;
        B     = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        in_op = 2'($urandom_range(0, 3));
    endtask

    // Issues one operation and waits for done; optionally pokes start and
    // mt writes at cycle poke_at to confirm they are ignored while busy.
    task automatic runOp(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input int poke_at);
        int cycles;
        int hold_errs;
        int busy_errs;
        applyStimulus(op, a, b);
        checkOutput({name, "_busy_start"}, 64'(busy), 64'd1);
        checkOutput({name, "_done_low"}, 64'(done), 64'd0);
        cycles = 0;
        hold_errs = 0;
        busy_errs = 0;
        while (cycles < 100) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            start = 1'b0;
            in_mthi = 1'b0;
            in_mtlo = 1'b0;
            if (done) break;
            if (HI !== last_hi || LO !== last_lo) hold_errs++;
            if (busy !== 1'b1) busy_errs++;
            if (cycles == poke_at) begin
                start   = 1'b1;
                in_op   = 2'b11;
                A       = 32'hDEAD_BEEF;
                B       = 32'd3;
                in_mthi = 1'b1;
                in_mtlo = 1'b1;
            end
        end
        checkOutput({name, "_latency"}, 64'(cycles), 64'd33);
        checkOutput({name, "_hold"}, 64'(hold_errs), 64'd0);
        checkOutput({name, "_busy_run"}, 64'(busy_errs), 64'd0);
        checkOutput({name, "_busy_end"}, 64'(busy), 64'd0);
        checkOutput({name, "_hi"}, 64'(HI), 64'(exp_hi));
        checkOutput({name, "_lo"}, 64'(LO), 64'(exp_lo));
        last_hi = exp_hi;
        last_lo = exp_lo;
    endtask

    initial begin
        logic [63:0] r;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        vecs[0] = '{2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1] = '{2'b01, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 32'hFFFF_FFEB};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{2'b11, 32'd100,       32'd7, 32'd2,         32'd14};
        vecs[4] = '{2'b11, 32'd5,         32'd0, 32'd5,         32'hFFFF_FFFF};
        vecs[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000};
        vecs[6] = '{2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF};

        reset = 1'b1;
        start = 1'b0;
        in_op = 2'b00;
        A = 32'd0;
        B = 32'd0;
        in_mthi = 1'b0;
        in_mtlo = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_hi", 64'(HI), 64'd0);
        checkOutput("reset_lo", 64'(LO), 64'd0);
        last_hi = 32'd0;
        last_lo = 32'd0;

        for (int i = 0; i < 7; i++) begin
            runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].hi, vecs[i].lo, (i == 0) ? 10 : -1);
        end

        in_mthi = 1'b1;
        in_mtlo = 1'b1;
        A = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        in_mthi = 1'b0;
        in_mtlo = 1'b0;
        checkOutput("mt_hi", 64'(HI), 64'h1234_5678);
        checkOutput("mt_lo", 64'(LO), 64'h1234_5678);
        last_hi = 32'h1234_5678;
        last_lo = 32'h1234_5678;

        applyStimulus(2'b00, 32'd1000, 32'd1000);
        repeat (14) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midreset_busy", 64'(busy), 64'd0);
        checkOutput("midreset_done", 64'(done), 64'd0);
        checkOutput("midreset_hi", 64'(HI), 64'd0);
        checkOutput("midreset_lo", 64'(LO), 64'd0);
        last_hi = 32'd0;
        last_lo = 32'd0;
        runOp("after_reset", 2'b01, 32'h0001_0000, 32'h0003_0000, 32'd3, 32'd0, -1);

        for (int i = 0; i < 8; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            r   = refModel(rop, ra, rb);
            runOp($sformatf("rand%0d", i), rop, ra, rb, r[63:32], r[31:0], -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative 32-bit multiply/divide unit for the MIPS datapath, executing MULT, MULTU, DIV and DIVU into the architectural HI/LO register pair. It sits beside the combinational ALU: it takes the same A/B register operands, runs for a fixed number of cycles, and raises busy so the control unit can stall MFHI/MFLO and any new multiply/divide. It also implements MTHI/MTLO writes.

## Interface
Parameters:
- none (width fixed at 32; the iteration count of 32 is a package constant)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- start  input  1  request to begin the operation given by in_op
- in_op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- A  input  32  multiplicand or dividend (rs)
- B  input  32  multiplier or divisor (rt)
- in_mthi  input  1  write A into HI
- in_mtlo  input  1  write A into LO
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when HI/LO receive a new result
- HI  output  32  HI register (product[63:32] or remainder)
- LO  output  32  LO register (product[31:0] or quotient)

## Operation
- States: IDLE, CALC, FIX.
- IDLE: if start=1, latch op, magnitudes of A/B (signed ops take two's-complement absolute values; unsigned ops use them raw), and result-sign flags; iteration counter := 0; go to CALC. start with in_mthi/in_mtlo in the same cycle: start wins, mt writes ignored. Without start, in_mthi/in_mtlo write A into HI/LO (both may fire in one cycle).
- CALC: one radix-2 step per cycle, counter increments 0..31; after the step at count 31, go to FIX.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring shift-subtract; 64-bit remainder/quotient register.
- FIX: apply signs and write HI/LO; done=1; go to IDLE.
  - MULT: negate the 64-bit product if operand signs differ.
  - DIV: quotient negated if signs differ; remainder takes the dividend's sign.
- Divide by zero (B=0, DIV or DIVU): LO=32'hFFFFFFFF, HI=A. Full latency still applies.
- DIV 32'h80000000 / 32'hFFFFFFFF: LO=32'h80000000, HI=0.
- start, in_mthi and in_mtlo are ignored while busy=1. A/B/in_op are not required to stay stable after the start cycle.

## Timing
- Reset values: busy=0, done=0, HI=0, LO=0, state IDLE, counter 0.
- start sampled at edge E0 → busy=1 after E0. CALC occupies edges E1..E32. FIX at E33 writes HI/LO, done=1 and busy=0 after E33.
- Latency: 33 cycles from start edge to valid result. done is high for exactly one cycle.
- Back-to-back: new start accepted in the cycle done=1, which is the first cycle with busy=0.
- HI/LO change only at FIX, on mt writes, or on reset. They hold their old values during CALC.
- Reset mid-operation: the next edge forces IDLE, clears HI/LO, busy and done; the in-flight result is discarded.

## Structure
- Shared package/header mult_div_defs: op encodings (MULT, MULTU, DIV, DIVU), state encodings (IDLE, CALC, FIX), ITERATIONS=32.
- One natural sub-module: negate_cond_64, a conditional two's-complement unit. It is used for operand absolute values and for the FIX sign correction; 32-bit uses take the low half.
- FSM, counter and datapath registers stay in mult_div_unit.

## Test plan
- MULT A=32'hFFFFFFFD (−3), B=7 → after 33 cycles HI=32'hFFFFFFFF, LO=32'hFFFFFFEB, one-cycle done; MULTU with the same operands → HI=6, LO=32'hFFFFFFEB.
- DIV A=−7, B=2 → LO=32'hFFFFFFFD (−3), HI=32'hFFFFFFFF (−1); DIVU A=100, B=7 → LO=14, HI=2.
- DIVU A=5, B=0 → LO=32'hFFFFFFFF, HI=5; DIV 32'h80000000 by 32'hFFFFFFFF → LO=32'h80000000, HI=0.
- start pulsed again at cycle 10 with different operands while busy → ignored, first result intact. in_mthi with A=32'hDEADBEEF while busy → HI unchanged. After done, in_mthi/in_mtlo with A=32'h12345678 → HI=LO=32'h12345678 next cycle.
- reset asserted at cycle 15 of a MULT → next cycle busy=0, done=0, HI=LO=0. A fresh start then completes normally in 33 cycles.
- Randomized back-to-back ops, each start issued in its predecessor's done cycle → every result matches the reference model. Every busy period spans exactly 33 cycles.
